branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters in the fetch stage. Looks up the current fetch PC in the same cycle, classifies the instruction as call, return, conditional branch or jump, and drives the `type` / `inst_bj` / `next_pc` inputs of the return address stack. Consumes the stack's `target_pc` to form the predicted next fetch PC. Execute-stage resolution writes back through a single update port.

## Interface
Parameters:
- `IDX_W`, default 4: index width; the buffer holds 2^IDX_W entries (16 by default).

Ports:
- `clk` in 1: the block's only clock; all state changes on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `fetch_pc` in 32: PC being fetched this cycle; word aligned.
- `ras_target` in 32: top-of-stack value from the return address stack.
- `flush` in 1: synchronously invalidates all entries.
- `upd_valid` in 1: resolved control-flow instruction this cycle.
- `upd_pc` in 32: PC of the resolved instruction.
- `upd_target` in 32: resolved target address.
- `upd_type` in 2: kind of the resolved instruction; encoding as for `type`.
- `upd_taken` in 1: resolved direction.
- `hit` out 1: `fetch_pc` matches a valid entry.
- `inst_bj` out 1: equals `hit`; feeds the return address stack.
- `type` out 2: 00 conditional, 01 call (PUSH), 10 return (POP), 11 unconditional jump. Forced to 00 on a miss.
- `next_pc` out 32: `fetch_pc + 4`, the return address pushed on a call.
- `pred_taken` out 1: predicted direction.
- `pred_target` out 32: predicted next fetch PC.

## Operation
- Index is `pc[IDX_W+1:2]`.
- Tag is `pc[31:IDX_W+2]`.
- Each entry holds: valid, tag, 32-bit target, 2-bit type, 2-bit counter.
- Lookup is combinational from `fetch_pc`. `hit = valid & (tag == fetch_pc[31:IDX_W+2])`.
- `pred_taken`:
  - Miss: 0.
  - Type 01, 10 or 11: 1.
  - Type 00: counter[1].
- `pred_target`:
  - `pred_taken == 0`: `next_pc`.
  - Type 10: `ras_target`.
  - Otherwise: the stored target.
- Update when `upd_valid` is high, at entry `upd_pc[IDX_W+1:2]`:
  - **Hit** (valid and tag match): write target and type. For type 00, counter saturating-increments if taken and saturating-decrements if not taken; 11 stays 11 and 00 stays 00. For types 01, 10, 11, the counter is written to 11.
  - **Miss and `upd_taken = 1`**: allocate by overwriting the entry. Set valid and tag, write target and type, and write counter 10.
  - **Miss and `upd_taken = 0`**: no state change.
- `flush` clears every valid bit at the edge; counters, tags and targets are left unchanged.
- `flush` and `upd_valid` in the same cycle: flush wins, and nothing is allocated.
- Arithmetic: `next_pc` is modulo 2^32, so 0xFFFFFFFC gives 0x00000000.

## Timing
- Lookup outputs have zero-cycle latency. Update results are visible to lookups starting the cycle after the edge.
- Reset (asynchronous, at any time, including mid-update): all valid bits are cleared and all counters are set to 01, immediately.
- Output values while reset is asserted:
  - `hit`, `inst_bj`, `pred_taken`: 0.
  - `type`: 00.
  - `next_pc`, `pred_target`: `fetch_pc + 4`.
- Lookup and update to the same index in the same cycle: the lookup sees the pre-update contents, unless the bypass option below is enabled.
- No handshake: the update port is fire-and-forget, one update per cycle.

## Configuration
- `BTB_BYPASS_EN` defined:
  - When `upd_valid` is high, `flush` is low, and `upd_pc == fetch_pc`, the lookup outputs reflect the post-update entry in the same cycle: hit, type, target, and the new counter.
  - Entries written by a miss with `upd_taken = 0` are not bypassed.
- `BTB_BYPASS_EN` undefined: no forwarding; the update is visible one cycle later.

## Test plan
- Reset, then `fetch_pc` = 0x100 -> hit 0, type 00, `pred_target` 0x104.
- Update 0x200 (type 01, target 0x800, taken). Next cycle fetch 0x200 -> hit 1, type 01, `pred_taken` 1, `pred_target` 0x800, `next_pc` 0x204.
- Update 0x300 (type 10, taken). Fetch 0x300 with `ras_target` = 0x204 -> type 10, `pred_target` 0x204.
- Conditional branch 0x400 → 0x480, taken once (counter 10):
  - Then not taken twice (counter 00) -> `pred_taken` 0 and `pred_target` 0x404.
  - Then taken twice -> `pred_taken` 1.
- Aliasing: 0x400 is allocated, then 0x440 is updated taken (same index, `IDX_W` = 4) -> fetch 0x400 misses and fetch 0x440 hits. After that, `flush` -> both miss.
- Update and fetch of 0x500 in the same cycle:
  - `BTB_BYPASS_EN` undefined: hit 0 that cycle, hit 1 the next.
  - `BTB_BYPASS_EN` defined: hit 1 in the same cycle.
  - In both builds, assert `resetn` low mid-sequence -> hit drops to 0 immediately.

Source files
------------

// File: rtl/branch_target_buffer.sv
// branch_target_buffer
//   Direct-mapped branch target buffer with 2-bit saturating direction
//   counters for the fetch stage. Looks up i_fetch_pc combinationally,
//   classifies the instruction (cond/call/return/jump) for the return
//   address stack and forms the predicted next fetch PC. Execute-stage
//   resolution writes back through one fire-and-forget update port.
//
//   Optional macro: BTB_BYPASS_EN -- forward a same-cycle update whose PC
//   equals i_fetch_pc onto the lookup outputs.
//
// Ports
//   i_clk          clock, rising edge
//   i_resetn       asynchronous active-low reset
//   i_fetch_pc     PC being fetched (word aligned)
//   i_ras_target   top of return address stack
//   i_flush        invalidate all entries at the edge
//   i_upd_valid    resolved control-flow instruction this cycle
//   i_upd_pc       PC of resolved instruction
//   i_upd_target   resolved target
//   i_upd_type     00 cond, 01 call, 10 return, 11 jump
//   i_upd_taken    resolved direction
//   o_hit          fetch PC matches a valid entry
//   o_inst_bj      equals o_hit (to return address stack)
//   o_type         instruction kind, 00 on a miss
//   o_next_pc      fetch PC + 4 (return address pushed on a call)
//   o_pred_taken   predicted direction
//   o_pred_target  predicted next fetch PC
module branch_target_buffer #(
  parameter int unsigned IDX_W = 4
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic [31:0] i_fetch_pc,
  input  logic [31:0] i_ras_target,
  input  logic        i_flush,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic [31:0] i_upd_target,
  input  logic [1:0]  i_upd_type,
  input  logic        i_upd_taken,
  output logic        o_hit,
  output logic        o_inst_bj,
  output logic [1:0]  o_type,
  output logic [31:0] o_next_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target
);

  localparam int unsigned N     = 1 << IDX_W;
  localparam int unsigned TAG_W = 30 - IDX_W;

  localparam logic [1:0] TY_COND = 2'b00;
  localparam logic [1:0] TY_RET  = 2'b10;

  logic             r_valid  [N];
  logic [TAG_W-1:0] r_tag    [N];
  logic [31:0]      r_target [N];
  logic [1:0]       r_type   [N];
  logic [1:0]       r_ctr    [N];

  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_upd_hit;
  logic             w_upd_we;
  logic [1:0]       w_upd_ctr;
  logic [1:0]       w_old_ctr;

  logic             w_sel_hit;
  logic [1:0]       w_sel_type;
  logic [31:0]      w_sel_target;
  logic [1:0]       w_sel_ctr;

  assign w_f_idx   = i_fetch_pc[IDX_W+1:2];
  assign w_f_tag   = i_fetch_pc[31:IDX_W+2];
  assign w_u_idx   = i_upd_pc[IDX_W+1:2];
  assign w_u_tag   = i_upd_pc[31:IDX_W+2];
  assign o_next_pc = i_fetch_pc + 32'd4;

  // Update: a hit refreshes the entry, a taken miss allocates, a
  // not-taken miss is dropped. Flush suppresses any write.
  assign w_upd_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_upd_we  = i_upd_valid && !i_flush && (w_upd_hit || i_upd_taken);
  assign w_old_ctr = r_ctr[w_u_idx];

  always_comb begin
    w_upd_ctr = 2'b10;
    if (w_upd_hit) begin
      if (i_upd_type == TY_COND) begin
        if (i_upd_taken)
          w_upd_ctr = (w_old_ctr == 2'b11) ? 2'b11 : w_old_ctr + 2'd1;
        else
          w_upd_ctr = (w_old_ctr == 2'b00) ? 2'b00 : w_old_ctr - 2'd1;
      end else begin
        w_upd_ctr = 2'b11;
      end
    end
  end

`ifdef BTB_BYPASS_EN
  logic w_byp;
  assign w_byp = w_upd_we && (i_upd_pc == i_fetch_pc);

  always_comb begin
    w_sel_hit    = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    w_sel_type   = r_type[w_f_idx];
    w_sel_target = r_target[w_f_idx];
    w_sel_ctr    = r_ctr[w_f_idx];
    if (w_byp) begin
      w_sel_hit    = 1'b1;
      w_sel_type   = i_upd_type;
      w_sel_target = i_upd_target;
      w_sel_ctr    = w_upd_ctr;
    end
  end
`else
  logic w_unused_pc_lsb;
  assign w_unused_pc_lsb = &{1'b0, i_upd_pc[1:0]};

  always_comb begin
    w_sel_hit    = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    w_sel_type   = r_type[w_f_idx];
    w_sel_target = r_target[w_f_idx];
    w_sel_ctr    = r_ctr[w_f_idx];
  end
`endif

  // Gating with i_resetn keeps the outputs quiet during reset even when a
  // bypassed update is presented.
  assign o_hit        = i_resetn && w_sel_hit;
  assign o_inst_bj    = o_hit;
  assign o_type       = o_hit ? w_sel_type : TY_COND;
  assign o_pred_taken = o_hit && ((w_sel_type != TY_COND) || w_sel_ctr[1]);

  always_comb begin
    o_pred_target = o_next_pc;
    if (o_pred_taken)
      o_pred_target = (w_sel_type == TY_RET) ? i_ras_target : w_sel_target;
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
    end else if (i_flush) begin
      for (int unsigned i = 0; i < N; i++) r_valid[i] <= 1'b0;
    end else if (w_upd_we) begin
      r_valid[w_u_idx] <= 1'b1;
      r_ctr[w_u_idx]   <= w_upd_ctr;
    end
  end

  // Payload fields need no reset; they are qualified by r_valid.
  always_ff @(posedge i_clk) begin
    if (w_upd_we) begin
      r_tag[w_u_idx]    <= w_u_tag;
      r_target[w_u_idx] <= i_upd_target;
      r_type[w_u_idx]   <= i_upd_type;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] fetch_pc;
  logic [31:0] ras_target;
  logic        flush;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic [1:0]  upd_type;
  logic        upd_taken;
  logic        hit;
  logic        inst_bj;
  logic [1:0]  typ;
  logic [31:0] next_pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  branch_target_buffer #(.IDX_W(4)) dut (
    .i_clk         (clk),
    .i_resetn      (resetn),
    .i_fetch_pc    (fetch_pc),
    .i_ras_target  (ras_target),
    .i_flush       (flush),
    .i_upd_valid   (upd_valid),
    .i_upd_pc      (upd_pc),
    .i_upd_target  (upd_target),
    .i_upd_type    (upd_type),
    .i_upd_taken   (upd_taken),
    .o_hit         (hit),
    .o_inst_bj     (inst_bj),
    .o_type        (typ),
    .o_next_pc     (next_pc),
    .o_pred_taken  (pred_taken),
    .o_pred_target (pred_target)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input int unsigned sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  // Expected lookup result; next_pc is always fetch_pc + 4.
  task automatic exp_lu(input string tag, input logic h, input logic [1:0] ty,
                        input logic pt, input logic [31:0] tgt);
    logic [31:0] npc;
    npc = fetch_pc + 32'd4;
    push({tag, ".hit"},         0, {31'b0, h});
    push({tag, ".inst_bj"},     1, {31'b0, h});
    push({tag, ".type"},        2, {30'b0, ty});
    push({tag, ".next_pc"},     3, npc);
    push({tag, ".pred_taken"},  4, {31'b0, pt});
    push({tag, ".pred_target"}, 5, tgt);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       obs = {31'b0, hit};
        1:       obs = {31'b0, inst_bj};
        2:       obs = {30'b0, typ};
        3:       obs = next_pc;
        4:       obs = {31'b0, pred_taken};
        default: obs = pred_target;
      endcase
      n_checks++;
      assert (obs === e.exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt,
                        input logic [1:0] ty, input logic tk);
    tick();
    flush      = 1'b0;
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    upd_type   = ty;
    upd_taken  = tk;
    fetch_pc   = 32'h0000_0F00;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic [31:0] ras,
                      input logic h, input logic [1:0] ty, input logic pt,
                      input logic [31:0] tgt);
    tick();
    upd_valid  = 1'b0;
    flush      = 1'b0;
    fetch_pc   = pc;
    ras_target = ras;
    exp_lu(tag, h, ty, pt, tgt);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    resetn     = 1'b0;
    fetch_pc   = 32'h0000_0100;
    ras_target = '0;
    flush      = 1'b0;
    upd_valid  = 1'b0;
    upd_pc     = '0;
    upd_target = '0;
    upd_type   = 2'b00;
    upd_taken  = 1'b0;

    @(negedge clk);
    exp_lu("in_reset", 1'b0, 2'b00, 1'b0, 32'h0000_0104);
    check_all();
    tick();
    resetn = 1'b1;

    look("miss_100", 32'h0000_0100, '0, 1'b0, 2'b00, 1'b0, 32'h0000_0104);

    do_upd(32'h0000_0200, 32'h0000_0800, 2'b01, 1'b1);
    look("call_200", 32'h0000_0200, '0, 1'b1, 2'b01, 1'b1, 32'h0000_0800);

    do_upd(32'h0000_0300, 32'h0000_0999, 2'b10, 1'b1);
    look("ret_300", 32'h0000_0300, 32'h0000_0204, 1'b1, 2'b10, 1'b1, 32'h0000_0204);

    // Conditional branch counter walk: 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10 -> 01
    do_upd(32'h0000_0400, 32'h0000_0480, 2'b00, 1'b1);
    look("c_alloc", 32'h0000_0400, '0, 1'b1, 2'b00, 1'b1, 32'h0000_0480);
    do_upd(32'h0000_0400, 32'h0000_0480, 2'b00, 1'b0);
    look("c_nt1", 32'h0000_0400, '0, 1'b1, 2'b00, 1'b0, 32'h0000_0404);
    do_upd(32'h0000_0400, 32'h0000_0480, 2'b00, 1'b0);
    look("c_nt2", 32'h0000_0400, '0, 1'b1, 2'b00, 1'b0, 32'h0000_0404);
    do_upd(32'h0000_0400, 32'h0000_0480, 2'b00, 1'b0);
    look("c_sat0", 32'h0000_0400, '0, 1'b1, 2'b00, 1'b0, 32'h0000_0404);
    do_upd(32'h0000_0400, 32'h0000_0480, 2'b00, 1'b1);
    look("c_t1", 32'h0000_0400, '0, 1'b1, 2'b00, 1'b0, 32'h0000_0404);
    do_upd(32'h0000_0400, 32'h0000_0480, 2'b00, 1'b1);
    look("c_t2", 32'h0000_0400, '0, 1'b1, 2'b00, 1'b1, 32'h0000_0480);
    do_upd(32'h0000_0400, 32'h0000_0480, 2'b00, 1'b1);
    do_upd(32'h0000_0400, 32'h0000_0480, 2'b00, 1'b1);
    do_upd(32'h0000_0400, 32'h0000_0480, 2'b00, 1'b0);
    look("c_sat3", 32'h0000_0400, '0, 1'b1, 2'b00, 1'b1, 32'h0000_0480);
    do_upd(32'h0000_0400, 32'h0000_0480, 2'b00, 1'b0);
    look("c_back01", 32'h0000_0400, '0, 1'b1, 2'b00, 1'b0, 32'h0000_0404);

    // Aliasing at index 0
    do_upd(32'h0000_0440, 32'h0000_1000, 2'b11, 1'b1);
    look("alias_400", 32'h0000_0400, '0, 1'b0, 2'b00, 1'b0, 32'h0000_0404);
    look("alias_440", 32'h0000_0440, '0, 1'b1, 2'b11, 1'b1, 32'h0000_1000);

    // Not-taken miss leaves the entry alone
    do_upd(32'h0000_0480, 32'h0000_2000, 2'b11, 1'b0);
    look("ntmiss_440", 32'h0000_0440, '0, 1'b1, 2'b11, 1'b1, 32'h0000_1000);
    look("ntmiss_480", 32'h0000_0480, '0, 1'b0, 2'b00, 1'b0, 32'h0000_0484);

    tick();
    upd_valid = 1'b0;
    flush     = 1'b1;
    look("flush_440", 32'h0000_0440, '0, 1'b0, 2'b00, 1'b0, 32'h0000_0444);
    look("flush_400", 32'h0000_0400, '0, 1'b0, 2'b00, 1'b0, 32'h0000_0404);

    do_upd(32'h0000_0600, 32'h0000_3000, 2'b11, 1'b1);
    flush = 1'b1;
    look("flush_wins", 32'h0000_0600, '0, 1'b0, 2'b00, 1'b0, 32'h0000_0604);

    // Same-cycle update and fetch of 0x500
    do_upd(32'h0000_0500, 32'h0000_0540, 2'b00, 1'b1);
    fetch_pc = 32'h0000_0500;
`ifdef BTB_BYPASS_EN
    exp_lu("same_cyc", 1'b1, 2'b00, 1'b1, 32'h0000_0540);
`else
    exp_lu("same_cyc", 1'b0, 2'b00, 1'b0, 32'h0000_0504);
`endif
    @(negedge clk);
    check_all();
    look("next_cyc", 32'h0000_0500, '0, 1'b1, 2'b00, 1'b1, 32'h0000_0540);

    // Asynchronous reset in the middle of an update
    do_upd(32'h0000_0500, 32'h0000_0540, 2'b00, 1'b1);
    fetch_pc = 32'h0000_0500;
    #1;
    exp_lu("pre_rst", 1'b1, 2'b00, 1'b1, 32'h0000_0540);
    check_all();
    resetn = 1'b0;
    #1;
    exp_lu("mid_rst", 1'b0, 2'b00, 1'b0, 32'h0000_0504);
    check_all();
    tick();
    resetn    = 1'b1;
    upd_valid = 1'b0;
    look("post_rst", 32'h0000_0500, '0, 1'b0, 2'b00, 1'b0, 32'h0000_0504);

    look("wrap", 32'hFFFF_FFFC, '0, 1'b0, 2'b00, 1'b0, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
